// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, ALUOp,
// ALU operation codes, opcodes, datapath select encodings and per-state control words.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // fetch_wr gates IRWrite/PCWrite with mem_ready; pc_branch gates PCWrite with zero
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic       fetch_wr;
    logic       pc_jump;
    logic       pc_branch;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    aluop_t     aluop;
  } ctrl_t;

  function automatic logic is_supported(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: ok = 1'b1;
      default:                                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.fetch_wr   = 1'b1;
        c.result_src = RES_ALURESULT;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_A;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = SRCA_A;
        c.alu_src_b = SRCB_B;
        c.aluop     = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alu_src_a = SRCA_A;
        c.alu_src_b = SRCB_IMM;
        c.aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_jump    = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_A;
        c.alu_src_b  = SRCB_B;
        c.aluop      = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.pc_branch  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps ALUOp plus funct3/funct7b5/opcode[5] onto the 3-bit ALUControl code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  // operation select; only register-register forms may subtract
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (funct7b5 && op5) alucontrol = ALU_SUB;
            else                 alucontrol = ALU_ADD;
          end
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// registers a per-state control word and gates all strobes with rst_n.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_instr
);

  state_t state_r;
  state_t next_s;
  ctrl_t  ctrl_r;

  // next-state decode; memory states hold until the cache reports completion
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) next_s = S_DECODE;
        else           next_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_s = S_MEMADR;
          OP_RTYPE:          next_s = S_EXECUTER;
          OP_ITYPE:          next_s = S_EXECUTEI;
          OP_JAL:            next_s = S_JAL;
          OP_BEQ:            next_s = S_BEQ;
          default:           next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LOAD) next_s = S_MEMREAD;
        else                   next_s = S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (mem_ready) next_s = S_MEMWB;
        else           next_s = S_MEMREAD;
      end
      S_MEMWRITE: begin
        if (mem_ready) next_s = S_FETCH;
        else           next_s = S_MEMWRITE;
      end
      S_MEMWB:    next_s = S_FETCH;
      S_EXECUTER: next_s = S_ALUWB;
      S_EXECUTEI: next_s = S_ALUWB;
      S_ALUWB:    next_s = S_FETCH;
      S_JAL:      next_s = S_ALUWB;
      S_BEQ:      next_s = S_FETCH;
      default:    next_s = S_FETCH;
    endcase
  end

  // state and the control word of the state being entered, so outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
      ctrl_r  <= ctrl_for(S_FETCH);
    end else begin
      state_r <= next_s;
      ctrl_r  <= ctrl_for(next_s);
    end
  end

  // immediate format follows the instruction register in every state
  always_comb begin
    ImmSrc = IMM_I;
    case (opcode)
      OP_STORE: ImmSrc = IMM_S;
      OP_BEQ:   ImmSrc = IMM_B;
      OP_JAL:   ImmSrc = IMM_J;
      default:  ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (ctrl_r.aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (opcode[5]),
    .alucontrol (ALUControl)
  );

  // strobes are forced low asynchronously while reset is held, abandoning any access
  assign mem_req       = rst_n & ctrl_r.mem_req;
  assign MemWrite      = rst_n & ctrl_r.mem_write;
  assign RegWrite      = rst_n & ctrl_r.reg_write;
  assign IRWrite       = rst_n & ctrl_r.fetch_wr & mem_ready;
  assign PCWrite       = rst_n & ((ctrl_r.fetch_wr & mem_ready) | ctrl_r.pc_jump |
                                  (ctrl_r.pc_branch & zero));
  assign illegal_instr = rst_n & (state_r == S_DECODE) & ~is_supported(opcode);

  assign AdrSrc    = ctrl_r.adr_src;
  assign ResultSrc = ctrl_r.result_src;
  assign ALUSrcA   = ctrl_r.alu_src_a;
  assign ALUSrcB   = ctrl_r.alu_src_b;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control vectors are
// queued as stimulus is applied and compared when the outputs settle.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int checks;
  int fails;

  logic [17:0] exp_q[$];
  string       tag_q[$];

  multicycle_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .MemWrite      (MemWrite),
    .AdrSrc        (AdrSrc),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ImmSrc        (ImmSrc),
    .ALUControl    (ALUControl),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  // {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal}
  function automatic logic [17:0] ex(input logic mr, input logic mw, input logic as,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] imm,
                                     input logic [2:0] ac, input logic ill);
    return {mr, mw, as, irw, pcw, rw, rs, sa, sb, imm, ac, ill};
  endfunction

  function automatic logic [17:0] e_fetch(input logic rdy, input logic [1:0] imm);
    return ex(1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [17:0] e_decode(input logic [1:0] imm, input logic ill);
    return ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, ill);
  endfunction
  function automatic logic [17:0] e_memadr(input logic [1:0] imm);
    return ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [17:0] e_memread(input logic [1:0] imm);
    return ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [17:0] e_memwb(input logic [1:0] imm);
    return ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [17:0] e_memwrite(input logic [1:0] imm);
    return ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [17:0] e_exr(input logic [1:0] imm, input logic [2:0] ac);
    return ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, ac, 1'b0);
  endfunction
  function automatic logic [17:0] e_exi(input logic [1:0] imm, input logic [2:0] ac);
    return ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, ac, 1'b0);
  endfunction
  function automatic logic [17:0] e_aluwb(input logic [1:0] imm);
    return ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [17:0] e_jal(input logic [1:0] imm);
    return ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, imm, 3'b000, 1'b0);
  endfunction
  function automatic logic [17:0] e_beq(input logic [1:0] imm, input logic z);
    return ex(1'b0, 1'b0, 1'b0, 1'b0, z, 1'b0, 2'b00, 2'b10, 2'b00, imm, 3'b001, 1'b0);
  endfunction
  function automatic logic [17:0] e_reset(input logic [1:0] imm);
    return ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0);
  endfunction

  task automatic push(input string tag, input logic [17:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    logic [17:0] obs;
    logic [17:0] e;
    string       t;
    obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr};
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%b expected=%b", t, obs, e);
      end
    end
  endtask

  // one clock cycle: apply inputs, queue expectation, compare mid-cycle
  task automatic cyc(input string tag, input logic rdy, input logic z, input logic [17:0] e);
    mem_ready = rdy;
    zero      = z;
    push(tag, e);
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0);

    // reset held: strobes low even with mem_ready high, selects at fetch values
    #12;
    push("reset_hold", e_reset(2'b00));
    check_pop();
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add then sub
    cyc("add_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b00));
    cyc("add_decode", 1'b1, 1'b0, e_decode(2'b00, 1'b0));
    cyc("add_exec", 1'b1, 1'b0, e_exr(2'b00, 3'b000));
    cyc("add_wb", 1'b1, 1'b0, e_aluwb(2'b00));
    set_instr(7'b0110011, 3'b000, 1'b1);
    cyc("sub_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b00));
    cyc("sub_decode", 1'b1, 1'b0, e_decode(2'b00, 1'b0));
    cyc("sub_exec", 1'b1, 1'b0, e_exr(2'b00, 3'b001));
    cyc("sub_wb", 1'b1, 1'b0, e_aluwb(2'b00));
    set_instr(7'b0110011, 3'b110, 1'b0);
    cyc("or_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b00));
    cyc("or_decode", 1'b1, 1'b0, e_decode(2'b00, 1'b0));
    cyc("or_exec", 1'b1, 1'b0, e_exr(2'b00, 3'b011));
    cyc("or_wb", 1'b1, 1'b0, e_aluwb(2'b00));
    set_instr(7'b0110011, 3'b111, 1'b0);
    cyc("and_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b00));
    cyc("and_decode", 1'b1, 1'b0, e_decode(2'b00, 1'b0));
    cyc("and_exec", 1'b1, 1'b0, e_exr(2'b00, 3'b010));
    cyc("and_wb", 1'b1, 1'b0, e_aluwb(2'b00));

    // addi with funct7b5 set never subtracts; slti
    set_instr(7'b0010011, 3'b000, 1'b1);
    cyc("addi_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b00));
    cyc("addi_decode", 1'b1, 1'b0, e_decode(2'b00, 1'b0));
    cyc("addi_exec", 1'b1, 1'b0, e_exi(2'b00, 3'b000));
    cyc("addi_wb", 1'b1, 1'b0, e_aluwb(2'b00));
    set_instr(7'b0010011, 3'b010, 1'b0);
    cyc("slti_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b00));
    cyc("slti_decode", 1'b1, 1'b0, e_decode(2'b00, 1'b0));
    cyc("slti_exec", 1'b1, 1'b0, e_exi(2'b00, 3'b101));
    cyc("slti_wb", 1'b1, 1'b0, e_aluwb(2'b00));

    // lw with three stall cycles in MEMREAD: 8 cycles total
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc("lw_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b00));
    cyc("lw_decode", 1'b1, 1'b0, e_decode(2'b00, 1'b0));
    cyc("lw_memadr", 1'b1, 1'b0, e_memadr(2'b00));
    for (int i = 0; i < 3; i++) cyc("lw_memread_stall", 1'b0, 1'b0, e_memread(2'b00));
    cyc("lw_memread_done", 1'b1, 1'b0, e_memread(2'b00));
    cyc("lw_memwb", 1'b1, 1'b0, e_memwb(2'b00));

    // sw with one fetch stall and one write stall
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw_fetch_stall", 1'b0, 1'b0, e_fetch(1'b0, 2'b01));
    cyc("sw_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b01));
    cyc("sw_decode", 1'b1, 1'b0, e_decode(2'b01, 1'b0));
    cyc("sw_memadr", 1'b1, 1'b0, e_memadr(2'b01));
    cyc("sw_memwrite_stall", 1'b0, 1'b0, e_memwrite(2'b01));
    cyc("sw_memwrite_done", 1'b1, 1'b0, e_memwrite(2'b01));

    // beq taken and not taken
    set_instr(7'b1100011, 3'b000, 1'b0);
    cyc("beq1_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b10));
    cyc("beq1_decode", 1'b1, 1'b0, e_decode(2'b10, 1'b0));
    cyc("beq1_branch", 1'b1, 1'b1, e_beq(2'b10, 1'b1));
    cyc("beq0_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b10));
    cyc("beq0_decode", 1'b1, 1'b0, e_decode(2'b10, 1'b0));
    cyc("beq0_branch", 1'b1, 1'b0, e_beq(2'b10, 1'b0));

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b11));
    cyc("jal_decode", 1'b1, 1'b0, e_decode(2'b11, 1'b0));
    cyc("jal_jump", 1'b1, 1'b0, e_jal(2'b11));
    cyc("jal_wb", 1'b1, 1'b0, e_aluwb(2'b11));

    // illegal opcode pulses once in DECODE and returns to FETCH
    set_instr(7'b0000000, 3'b000, 1'b0);
    cyc("ill_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b00));
    cyc("ill_decode", 1'b1, 1'b0, e_decode(2'b00, 1'b1));
    cyc("ill_refetch", 1'b0, 1'b0, e_fetch(1'b0, 2'b00));

    // reset mid-MEMWRITE drops the strobes before any clock edge
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("rst_sw_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b01));
    cyc("rst_sw_decode", 1'b1, 1'b0, e_decode(2'b01, 1'b0));
    cyc("rst_sw_memadr", 1'b1, 1'b0, e_memadr(2'b01));
    cyc("rst_sw_memwrite", 1'b0, 1'b0, e_memwrite(2'b01));
    #2;
    push("rst_sw_still_writing", e_memwrite(2'b01));
    check_pop();
    rst_n = 1'b0;
    #1;
    push("rst_async_drop", e_reset(2'b01));
    check_pop();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b0);
    @(posedge clk);
    #1;
    cyc("post_rst_fetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b00));
    cyc("post_rst_decode", 1'b1, 1'b0, e_decode(2'b00, 1'b0));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
